// File: rtl/psmac_accum.sv
// Precision-scalable signed MAC: 1x/2x/4x lane dot products per beat, accumulated over a
// last-framed vector and returned on valid/ready. Define PSMAC_SAT_EN for a saturating accumulator.
module psmac_accum #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic [CNT_W-1:0]  beats,
    output logic              overflow
);

    localparam int SUM_W = 2 * DATA_W + 2;
    localparam int HALF_W = DATA_W / 2;
    localparam int QTR_W = DATA_W / 4;

    localparam logic [1:0] ST_ACCUM  = 2'd0;
    localparam logic [1:0] ST_FLUSH  = 2'd1;
    localparam logic [1:0] ST_OUTPUT = 2'd2;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // Lane order does not affect the sum, so lanes are walked LSB-first.
    function automatic logic signed [SUM_W-1:0] lane_sum(input logic [DATA_W-1:0] x,
                                                         input logic [DATA_W-1:0] y,
                                                         input logic [1:0]        m);
        logic signed [SUM_W-1:0]  s;
        logic signed [DATA_W-1:0] xf;
        logic signed [DATA_W-1:0] yf;
        logic signed [HALF_W-1:0] xh;
        logic signed [HALF_W-1:0] yh;
        logic signed [QTR_W-1:0]  xq;
        logic signed [QTR_W-1:0]  yq;
        s  = '0;
        xf = x;
        yf = y;
        xh = '0;
        yh = '0;
        xq = '0;
        yq = '0;
        case (m)
            2'd1: begin
                for (int i = 0; i < 2; i++) begin
                    xh = x[i*HALF_W +: HALF_W];
                    yh = y[i*HALF_W +: HALF_W];
                    s  = s + SUM_W'(xh) * SUM_W'(yh);
                end
            end
            2'd2: begin
                for (int i = 0; i < 4; i++) begin
                    xq = x[i*QTR_W +: QTR_W];
                    yq = y[i*QTR_W +: QTR_W];
                    s  = s + SUM_W'(xq) * SUM_W'(yq);
                end
            end
            default: s = SUM_W'(xf) * SUM_W'(yf);
        endcase
        return s;
    endfunction

    // Returns {saturated, result}.
    function automatic logic [ACC_W:0] acc_add(input logic signed [ACC_W-1:0] x,
                                               input logic signed [ACC_W-1:0] y);
`ifdef PSMAC_SAT_EN
        logic [ACC_W:0] w;
        w = {x[ACC_W-1], x} + {y[ACC_W-1], y};
        if (w[ACC_W] != w[ACC_W-1])
            return {1'b1, (w[ACC_W] ? ACC_MIN : ACC_MAX)};
        return {1'b0, w[ACC_W-1:0]};
`else
        logic signed [ACC_W-1:0] w;
        w = x + y;
        return {1'b0, w};
`endif
    endfunction

    logic [1:0]              state_q, state_d;
    logic                    first_q, first_d;
    logic [1:0]              mode_q, mode_d;
    logic [CNT_W-1:0]        beats_q, beats_d;
    logic                    vld_p1_q, vld_p1_d;
    logic                    last_p1_q, last_p1_d;
    logic                    first_p1_q, first_p1_d;
    logic signed [SUM_W-1:0] sum_p1_q, sum_p1_d;
    logic                    done_p2_q, done_p2_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    ovf_q, ovf_d;

    logic                    accept;
    logic [1:0]              eff_mode;
    logic signed [ACC_W-1:0] sum_ext;
    logic [ACC_W:0]          add_res;

    always_comb begin
        accept     = in_valid && (state_q == ST_ACCUM);
        eff_mode   = first_q ? mode : mode_q;
        mode_d     = (accept && first_q) ? mode : mode_q;
        first_d    = accept ? last : first_q;

        beats_d = beats_q;
        if (accept) begin
            if (first_q)
                beats_d = CNT_W'(1);
            else if (beats_q != {CNT_W{1'b1}})
                beats_d = beats_q + CNT_W'(1);
        end

        // Stage 1: beat sum, framing and first-beat flag.
        vld_p1_d   = accept;
        last_p1_d  = accept && last;
        first_p1_d = accept && first_q;
        sum_p1_d   = lane_sum(a, b, eff_mode);

        // Stage 2: load or accumulate.
        sum_ext   = ACC_W'(sum_p1_q);
        add_res   = acc_add(acc_q, sum_ext);
        done_p2_d = vld_p1_q && last_p1_q;
        acc_d     = acc_q;
        ovf_d     = ovf_q;
        if (vld_p1_q) begin
            if (first_p1_q) begin
                acc_d = sum_ext;
                ovf_d = 1'b0;
            end else begin
                acc_d = add_res[ACC_W-1:0];
                ovf_d = ovf_q | add_res[ACC_W];
            end
        end

        state_d = state_q;
        case (state_q)
            ST_ACCUM:  if (accept && last) state_d = ST_FLUSH;
            ST_FLUSH:  if (done_p2_q) state_d = ST_OUTPUT;
            ST_OUTPUT: if (out_ready) state_d = ST_ACCUM;
            default:   state_d = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_ACCUM;
            first_q    <= 1'b1;
            mode_q     <= 2'd0;
            beats_q    <= '0;
            vld_p1_q   <= 1'b0;
            last_p1_q  <= 1'b0;
            first_p1_q <= 1'b0;
            done_p2_q  <= 1'b0;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            first_q    <= first_d;
            mode_q     <= mode_d;
            beats_q    <= beats_d;
            vld_p1_q   <= vld_p1_d;
            last_p1_q  <= last_p1_d;
            first_p1_q <= first_p1_d;
            done_p2_q  <= done_p2_d;
            acc_q      <= acc_d;
            ovf_q      <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        sum_p1_q <= sum_p1_d;
    end

    assign in_ready  = (state_q == ST_ACCUM);
    assign out_valid = (state_q == ST_OUTPUT);
    assign acc_out   = acc_q;
    assign beats     = beats_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_psmac_accum.sv
// Directed bench for psmac_accum: vector table plus hand sequences for mode latch, gaps,
// backpressure, async reset and accumulator overflow (ACC_W=16 instance, PSMAC_SAT_EN aware).
module tb_psmac_accum;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mode;
    logic        in_valid;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        last;
    logic        out_ready;

    logic        in_ready, out_valid, overflow;
    logic [23:0] acc_out;
    logic [15:0] beats;

    logic        in_ready16, out_valid16, overflow16;
    logic [15:0] acc_out16;
    logic [15:0] beats16;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    psmac_accum #(.DATA_W(8), .ACC_W(24), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .last(last), .out_valid(out_valid), .out_ready(out_ready),
        .acc_out(acc_out), .beats(beats), .overflow(overflow)
    );

    psmac_accum #(.DATA_W(8), .ACC_W(16), .CNT_W(16)) dut16 (
        .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready16),
        .a(a), .b(b), .last(last), .out_valid(out_valid16), .out_ready(out_ready),
        .acc_out(acc_out16), .beats(beats16), .overflow(overflow16)
    );

    typedef struct {
        logic [1:0] m;
        logic [7:0] a;
        logic [7:0] b;
        int         n;
        longint     exp_acc;
        longint     exp_beats;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic beat(input logic [1:0] m, input logic [7:0] x, input logic [7:0] y,
                        input logic l);
        mode = m;
        a = x;
        b = y;
        last = l;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        last = 1'b0;
    endtask

    task automatic wait_result(input string name);
        int lat;
        lat = 0;
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({name, "_latency"}, lat, 2);
    endtask

    task automatic check_result(input string name, input longint exp_acc, input longint exp_beats);
        chk({name, "_valid"}, out_valid, 1);
        chk({name, "_acc"}, longint'($signed(acc_out)), exp_acc);
        chk({name, "_beats"}, beats, exp_beats);
        chk({name, "_ovf"}, overflow, 0);
    endtask

    task automatic release_result(input string name);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({name, "_valid_drop"}, out_valid, 0);
        chk({name, "_ready_back"}, in_ready, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        mode = 2'd0;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        last = 1'b0;
        out_ready = 1'b0;
        #12;
        chk("rst_acc", acc_out, 0);
        chk("rst_beats", beats, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", in_ready, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        vecs[0] = '{2'd0, 8'h80, 8'h80, 1, 16384, 1};
        vecs[1] = '{2'd1, 8'h78, 8'h32, 1, 5, 1};
        vecs[2] = '{2'd1, 8'h78, 8'h32, 3, 15, 3};
        vecs[3] = '{2'd2, 8'b01_10_11_00, 8'b01_11_11_01, 1, 4, 1};
        vecs[4] = '{2'd3, 8'h7f, 8'h81, 1, -16129, 1};
        vecs[5] = '{2'd0, 8'h80, 8'h7f, 2, -32512, 2};

        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < vecs[i].n; k++)
                beat(vecs[i].m, vecs[i].a, vecs[i].b, (k == vecs[i].n - 1));
            wait_result($sformatf("vec%0d", i));
            check_result($sformatf("vec%0d", i), vecs[i].exp_acc, vecs[i].exp_beats);
            release_result($sformatf("vec%0d", i));
        end

        // Mode change on the second beat must be ignored: 5 + 5.
        beat(2'd1, 8'h78, 8'h32, 1'b0);
        beat(2'd0, 8'h78, 8'h32, 1'b1);
        wait_result("latch");
        check_result("latch", 10, 2);
        release_result("latch");

        // Idle cycles inside a vector.
        beat(2'd2, 8'b01_10_11_00, 8'b01_11_11_01, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        beat(2'd2, 8'b01_10_11_00, 8'b01_11_11_01, 1'b1);
        wait_result("gap");
        check_result("gap", 8, 2);
        release_result("gap");

        // Result held under backpressure; offered beats are refused.
        beat(2'd0, 8'd20, 8'd10, 1'b1);
        wait_result("bp");
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp%0d_ready", c), in_ready, 0);
            chk($sformatf("bp%0d_valid", c), out_valid, 1);
            chk($sformatf("bp%0d_acc", c), longint'($signed(acc_out)), 200);
            chk($sformatf("bp%0d_beats", c), beats, 1);
        end
        in_valid = 1'b0;
        release_result("bp");

        // Asynchronous reset in the middle of a vector.
        beat(2'd0, 8'd10, 8'd10, 1'b0);
        beat(2'd0, 8'd10, 8'd10, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("mrst_acc", acc_out, 0);
        chk("mrst_beats", beats, 0);
        chk("mrst_ovf", overflow, 0);
        chk("mrst_valid", out_valid, 0);
        chk("mrst_ready", in_ready, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        beat(2'd0, 8'd3, 8'hfb, 1'b1);
        wait_result("post_rst");
        check_result("post_rst", -15, 1);
        release_result("post_rst");

        // 2 x 16384 exceeds a 16-bit accumulator.
        beat(2'd0, 8'h80, 8'h80, 1'b0);
        beat(2'd0, 8'h80, 8'h80, 1'b1);
        wait_result("ovf");
        check_result("ovf", 32768, 2);
        chk("ovf16_valid", out_valid16, 1);
        chk("ovf16_beats", beats16, 2);
`ifdef PSMAC_SAT_EN
        chk("ovf16_acc", longint'($signed(acc_out16)), 32767);
        chk("ovf16_flag", overflow16, 1);
`else
        chk("ovf16_acc", longint'($signed(acc_out16)), -32768);
        chk("ovf16_flag", overflow16, 0);
`endif
        release_result("ovf");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
